branch_flush_ctrl: RTL and testbench

BRANCH_FLUSH_CTRL -- requirements
Module: branch_flush_ctrl

---
 rtl/branch_flush_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_branch_flush_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_flush_ctrl.sv
// -----------------------------------------------------------------------------
// branch_flush_ctrl
//
// Purpose:
//   Resolves branches and jumps in the EX stage. When the actual outcome
//   differs from the prediction that travelled with the instruction, the
//   block does the following:
//     - issues a one-cycle PC redirect;
//     - squashes the IF/ID and ID/EX registers for FLUSH_LEN cycles in total;
//     - bumps a saturating mispredict counter.
//   An optional bimodal predictor (2-bit saturating counters) provides
//   pred_taken for the fetch PC.
//
// Configuration:
//   BRANCH_PREDICT_EN  (macro)  defined   -> branch history table is built.
//                               undefined -> pred_taken is tied to 0, which
//                                            gives static not-taken.
//
// Parameters:
//   FLUSH_LEN  (1..15)  total cycles the flush outputs stay high per mispredict
//   BHT_IDX_W           predictor index width (2**BHT_IDX_W entries)
//   CNT_W               mispredict counter width
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   ex_valid       in   EX holds a branch/jump
//   ex_is_jump     in   EX instruction is JAL/JALR
//   br_taken       in   branch condition result
//   ex_pred_taken  in   prediction carried with the EX instruction
//   ex_pc          in   PC of the EX instruction
//   ex_target      in   computed taken target
//   stall          in   pipeline stall
//   if_pc          in   fetch PC for prediction lookup
//   pred_taken     out  prediction for if_pc
//   redirect_valid out  load redirect_pc into the PC
//   redirect_pc    out  corrected fetch address
//   flush_ifid     out  squash IF/ID
//   flush_idex     out  squash ID/EX
//   busy           out  FSM not idle
//   mispredict_cnt out  saturating count of mispredicts
// -----------------------------------------------------------------------------
module branch_flush_ctrl #(
  parameter int FLUSH_LEN = 2,
  parameter int BHT_IDX_W = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_is_jump,
  input  logic             br_taken,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target,
  input  logic             stall,
  input  logic [31:0]      if_pc,
  output logic             pred_taken,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             busy,
  output logic [CNT_W-1:0] mispredict_cnt
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REDIRECT = 2'd1,
    S_FLUSH    = 2'd2
  } state_t;

  // The REDIRECT cycle already counts as one flush cycle, so FLUSH starts
  // with the cycles that remain.
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_LEN - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_flush_cnt;
  logic [3:0]         w_flush_cnt_nxt;
  logic [31:0]        r_redirect_pc;
  logic [CNT_W-1:0]   r_mp_cnt;

  logic               w_resolve;
  logic               w_actual;
  logic               w_mispredict;
  logic [31:0]        w_target;
  logic               w_unused_if_pc;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [1:0] bht_next(input logic [1:0] e, input logic taken);
    logic [1:0] r;
    r = e;
    if (taken) begin
      if (e != 2'b11) r = e + 2'b01;
    end else begin
      if (e != 2'b00) r = e - 2'b01;
    end
    return r;
  endfunction

  // Resolution only happens in IDLE. In the other states the EX stage holds
  // wrong-path work, which must not redirect or train the predictor.
  assign w_resolve    = (r_state == S_IDLE) && ex_valid && !stall;
  assign w_actual     = ex_is_jump | br_taken;
  assign w_mispredict = w_resolve && (w_actual != ex_pred_taken);
  assign w_target     = w_actual ? ex_target : (ex_pc + 32'd4);

  // Only the index bits of if_pc feed the predictor, and none are used
  // without it.
  assign w_unused_if_pc = ^if_pc;

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    redirect_valid  = 1'b0;
    flush_ifid      = 1'b0;
    flush_idex      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mispredict) w_state_nxt = S_REDIRECT;
      end
      S_REDIRECT: begin
        // Lasts exactly one cycle, even under stall.
        redirect_valid = 1'b1;
        flush_ifid     = 1'b1;
        flush_idex     = 1'b1;
        if (FLUSH_LEN <= 1) begin
          w_state_nxt     = S_IDLE;
          w_flush_cnt_nxt = 4'd0;
        end else begin
          w_state_nxt     = S_FLUSH;
          w_flush_cnt_nxt = FLUSH_INIT;
        end
      end
      S_FLUSH: begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
        if (!stall) begin
          if (r_flush_cnt <= 4'd1) begin
            w_state_nxt     = S_IDLE;
            w_flush_cnt_nxt = 4'd0;
          end else begin
            w_flush_cnt_nxt = r_flush_cnt - 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_flush_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_flush_cnt   <= 4'd0;
      r_redirect_pc <= 32'd0;
      r_mp_cnt      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      if (w_mispredict) begin
        r_redirect_pc <= w_target;
        r_mp_cnt      <= sat_inc_cnt(r_mp_cnt);
      end
    end
  end

  assign busy           = (r_state != S_IDLE);
  assign redirect_pc    = r_redirect_pc;
  assign mispredict_cnt = r_mp_cnt;

`ifdef BRANCH_PREDICT_EN
  localparam int BHT_N = 1 << BHT_IDX_W;

  logic [1:0]           r_bht [BHT_N];
  logic [BHT_IDX_W-1:0] w_if_idx;
  logic [BHT_IDX_W-1:0] w_ex_idx;

  assign w_if_idx = if_pc[BHT_IDX_W+1:2];
  assign w_ex_idx = ex_pc[BHT_IDX_W+1:2];

  // Read straight from the registered table, so a same-cycle update to the
  // same index is seen only from the next cycle on.
  assign pred_taken = r_bht[w_if_idx][1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) r_bht[i] <= 2'b01;
    end else if (w_resolve && !ex_is_jump) begin
      r_bht[w_ex_idx] <= bht_next(r_bht[w_ex_idx], br_taken);
    end
  end
`else
  assign pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_branch_flush_ctrl.sv
module tb_branch_flush_ctrl;

  logic        clk = 1'b0;
  logic        rst, ex_valid, ex_is_jump, br_taken, ex_pred_taken, stall;
  logic [31:0] ex_pc, ex_target, if_pc;

  logic        p2, rv2, fi2, fx2, b2;
  logic [31:0] rpc2;
  logic [15:0] cnt2;
  logic        p3, rv3, fi3, fx3, b3;
  logic [31:0] rpc3;
  logic [1:0]  cnt3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_flush_ctrl #(.FLUSH_LEN(2), .BHT_IDX_W(4), .CNT_W(16)) u_dut2 (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_jump(ex_is_jump),
    .br_taken(br_taken), .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc),
    .ex_target(ex_target), .stall(stall), .if_pc(if_pc),
    .pred_taken(p2), .redirect_valid(rv2), .redirect_pc(rpc2),
    .flush_ifid(fi2), .flush_idex(fx2), .busy(b2), .mispredict_cnt(cnt2));

  branch_flush_ctrl #(.FLUSH_LEN(3), .BHT_IDX_W(4), .CNT_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_jump(ex_is_jump),
    .br_taken(br_taken), .ex_pred_taken(ex_pred_taken), .ex_pc(ex_pc),
    .ex_target(ex_target), .stall(stall), .if_pc(if_pc),
    .pred_taken(p3), .redirect_valid(rv3), .redirect_pc(rpc3),
    .flush_ifid(fi3), .flush_idex(fx3), .busy(b3), .mispredict_cnt(cnt3));

  typedef struct {
    string       nm;
    logic        r, ev, jmp, tk, pt, st;
    logic [31:0] pc, tgt;
    logic        rv, fi, fx, bsy;
    logic [31:0] rpc;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic sv(input int i, input string nm,
                    input logic r, input logic ev, input logic jmp, input logic tk,
                    input logic pt, input logic st, input logic [31:0] pc,
                    input logic [31:0] tgt, input logic rv, input logic fi,
                    input logic fx, input logic bsy, input logic [31:0] rpc,
                    input logic [15:0] cnt);
    tbl[i].nm = nm; tbl[i].r = r; tbl[i].ev = ev; tbl[i].jmp = jmp;
    tbl[i].tk = tk; tbl[i].pt = pt; tbl[i].st = st; tbl[i].pc = pc;
    tbl[i].tgt = tgt; tbl[i].rv = rv; tbl[i].fi = fi; tbl[i].fx = fx;
    tbl[i].bsy = bsy; tbl[i].rpc = rpc; tbl[i].cnt = cnt;
  endtask

  task automatic drive(input logic r, input logic ev, input logic jmp, input logic tk,
                       input logic pt, input logic st, input logic [31:0] pc,
                       input logic [31:0] tgt);
    rst = r; ex_valid = ev; ex_is_jump = jmp; br_taken = tk;
    ex_pred_taken = pt; stall = st; ex_pc = pc; ex_target = tgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!b2 && !b3) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(nm, {63'd0, ok}, 64'd1);
  endtask

  initial begin
    int fl_cnt;
    int rv_cnt;
    logic done;
    logic [1:0] exp3;
    logic tk_pat [5];
    logic pr_pat [5];

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    if_pc = 32'd0;

    //   idx name           rst ev jmp tk pt st  pc            tgt           rv fi fx bsy rpc           cnt
    sv(0,  "reset",        1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        16'd0);
    sv(1,  "idle_quiet",   0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        16'd0);
    sv(2,  "taken_mp",     0, 1, 0, 1, 0, 0, 32'h0,        32'h100,      1, 1, 1, 1, 32'h100,      16'd1);
    sv(3,  "flush1",       0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 1, 1, 32'h100,      16'd1);
    sv(4,  "back_idle",    0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h100,      16'd1);
    sv(5,  "nt_mp",        0, 1, 0, 0, 1, 0, 32'h2000,     32'h900,      1, 1, 1, 1, 32'h2004,     16'd2);
    sv(6,  "wp_in_redir",  0, 1, 0, 1, 0, 0, 32'h80,       32'h300,      0, 1, 1, 1, 32'h2004,     16'd2);
    sv(7,  "wp_in_flush",  0, 1, 0, 1, 0, 0, 32'h80,       32'h300,      0, 0, 0, 0, 32'h2004,     16'd2);
    sv(8,  "correct_pred", 0, 1, 0, 1, 1, 0, 32'h80,       32'h300,      0, 0, 0, 0, 32'h2004,     16'd2);
    sv(9,  "jump_mp",      0, 1, 1, 0, 0, 0, 32'h44,       32'h500,      1, 1, 1, 1, 32'h500,      16'd3);
    sv(10, "redir_stall",  0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        0, 1, 1, 1, 32'h500,      16'd3);
    sv(11, "flush_stall",  0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        0, 1, 1, 1, 32'h500,      16'd3);
    sv(12, "flush_done",   0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h500,      16'd3);
    sv(13, "stalled_res",  0, 1, 0, 1, 0, 1, 32'h10,       32'h600,      0, 0, 0, 0, 32'h500,      16'd3);
    sv(14, "pc_wrap",      0, 1, 0, 0, 1, 0, 32'hFFFFFFFC, 32'h700,      1, 1, 1, 1, 32'h0,        16'd4);
    sv(15, "rst_in_redir", 1, 1, 0, 1, 0, 0, 32'h0,        32'h800,      0, 0, 0, 0, 32'h0,        16'd0);
    sv(16, "after_rst",    0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        16'd0);

    tick();
    tick();
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].r, tbl[i].ev, tbl[i].jmp, tbl[i].tk, tbl[i].pt, tbl[i].st,
            tbl[i].pc, tbl[i].tgt);
      tick();
      chk(tbl[i].nm, {12'd0, rv2, fi2, fx2, b2, rpc2, cnt2},
          {12'd0, tbl[i].rv, tbl[i].fi, tbl[i].fx, tbl[i].bsy, tbl[i].rpc, tbl[i].cnt});
    end

    // Stall inside FLUSH with FLUSH_LEN=3.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h700);
    tick();
    fl_cnt = (fi3 && fx3) ? 1 : 0;
    rv_cnt = rv3 ? 1 : 0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      stall = (k == 1 || k == 2);
      tick();
      if (fi3 && fx3) fl_cnt++;
      if (rv3) rv_cnt++;
      if (!b3) begin
        done = 1'b1;
        break;
      end
    end
    stall = 1'b0;
    chk("stall_flush_cycles", 64'(fl_cnt), 64'd5);
    chk("stall_redirect_cycles", 64'(rv_cnt), 64'd1);
    chk("stall_done", {63'd0, done}, 64'd1);
    chk("len3_rpc", {32'd0, rpc3}, 64'h700);
    wait_idle("idle_after_stall");

    // Counter saturation on the 2-bit instance; the 16-bit one keeps counting.
    for (int n = 2; n <= 4; n++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'(n * 16), 32'h0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      wait_idle("idle_sat");
      exp3 = (n >= 3) ? 2'd3 : 2'(n);
      chk("sat_cnt3", {62'd0, cnt3}, {62'd0, exp3});
      chk("cnt2", {48'd0, cnt2}, 64'(n));
      chk("nt_rpc3", {32'd0, rpc3}, 64'(n * 16 + 4));
    end

`ifdef BRANCH_PREDICT_EN
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    if_pc = 32'h40;
    #1;
    chk("bht_reset_pred", {63'd0, p2}, 64'd0);
    tk_pat[0] = 1'b1; tk_pat[1] = 1'b1; tk_pat[2] = 1'b1; tk_pat[3] = 1'b0; tk_pat[4] = 1'b0;
    // 01 -> 10 -> 11 -> 11 -> 10 -> 01
    pr_pat[0] = 1'b1; pr_pat[1] = 1'b1; pr_pat[2] = 1'b1; pr_pat[3] = 1'b1; pr_pat[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b0, tk_pat[i], tk_pat[i], 1'b0, 32'h40, 32'h1000);
      #1;
      chk("bht_pre_update", {63'd0, p2}, {63'd0, (i == 0) ? 1'b0 : pr_pat[i-1]});
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      chk("bht_post_update", {63'd0, p2}, {63'd0, pr_pat[i]});
    end
    if_pc = 32'h44;
    #1;
    chk("bht_other_entry", {63'd0, p3}, 64'd0);
`else
    if_pc = 32'h40;
    #1;
    chk("static_nt_pred2", {63'd0, p2}, 64'd0);
    if_pc = 32'hFFFFFFFC;
    #1;
    chk("static_nt_pred3", {63'd0, p3}, 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
